// File: rtl/ram_burst_wr.sv
// ram_burst_wr
// ------------
// 64 x 4 RAM that loads itself from a valid/ready stream. Each burst writes
// words at consecutive addresses. It has the same combinational read port as
// the 64x4 ROM, so downstream logic can read a table that was loaded at run
// time.
//
// Ports
//   clk        rising-edge clock for all state
//   rst        synchronous, active-high reset (FSM and pointers only)
//   start      burst request, sampled only while idle
//   base_addr  first write address, latched with start
//   len        burst length in words (0..2*DEPTH-1), saturated to DEPTH
//   din        write data
//   din_valid  din is valid this cycle
//   din_ready  block accepts din this cycle (WRITE state)
//   busy       burst in progress (WRITE or DONE)
//   done       one-cycle completion pulse
//   en         read enable
//   addr       read address
//   dout       en ? mem[addr] : 0, combinational, no write bypass
module ram_burst_wr #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 4,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              busy,
  output logic              done,
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] dout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_LEN = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_LEN   = (ADDR_W + 1)'(1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   remaining_q, remaining_d;
  logic [ADDR_W:0]   len_sat;
  logic              wr_en;

  // Storage has no reset: a table loaded before a reset must survive it.
  logic [DATA_W-1:0] mem_q [DEPTH];

  // A burst can never cover more than the whole array.
  assign len_sat = (len > DEPTH_LEN) ? DEPTH_LEN : len;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    remaining_d = remaining_q;
    busy        = 1'b0;
    din_ready   = 1'b0;
    done        = 1'b0;
    wr_en       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          ptr_d       = base_addr;
          remaining_d = len_sat;
          // A zero-length burst still reports completion, without writing.
          state_d     = (len_sat == '0) ? DONE : WRITE;
        end
      end

      WRITE: begin
        busy      = 1'b1;
        din_ready = 1'b1;
        if (din_valid) begin
          wr_en       = 1'b1;
          ptr_d       = ptr_q + 1'b1;        // natural wrap 63 -> 0
          remaining_d = remaining_q - 1'b1;  // WRITE is only entered with remaining > 0
          if (remaining_q == ONE_LEN) begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      remaining_q <= remaining_d;
    end
  end

  // A handshake that coincides with a reset edge is dropped.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      mem_q[ptr_q] <= din;
    end
  end

  // Asynchronous read. A write shows up only after its edge.
  assign dout = en ? mem_q[addr] : '0;

endmodule

// File: tb/tb_ram_burst_wr.sv
// Self-checking bench for ram_burst_wr: randomized bursts and reads, checked
// every cycle against a behavioural model plus literal expectations.
module tb_ram_burst_wr;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [5:0] base_addr;
  logic [6:0] len;
  logic [3:0] din;
  logic       din_valid;
  logic       din_ready;
  logic       busy;
  logic       done;
  logic       en;
  logic [5:0] addr;
  logic [3:0] dout;

  int checks = 0;
  int errors = 0;
  bit checking = 1'b0;

  // Behavioural model: burst bookkeeping as plain counters plus a shadow memory.
  logic [3:0] m_mem   [64];
  bit         m_known [64];
  bit         m_in_burst = 1'b0;
  bit         m_done     = 1'b0;
  int         m_left     = 0;
  int         m_ptr      = 0;

  ram_burst_wr dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .busy      (busy),
    .done      (done),
    .en        (en),
    .addr      (addr),
    .dout      (dout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Advance the model by one rising edge using the inputs present at that edge.
  task automatic model_edge();
    if (rst) begin
      m_in_burst = 1'b0;
      m_done     = 1'b0;
      m_left     = 0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_in_burst) begin
      if (din_valid) begin
        m_mem[m_ptr]   = din;
        m_known[m_ptr] = 1'b1;
        m_ptr          = (m_ptr + 1) % 64;
        m_left         = m_left - 1;
        if (m_left == 0) begin
          m_in_burst = 1'b0;
          m_done     = 1'b1;
        end
      end
    end else if (start) begin
      m_ptr  = int'(base_addr);
      m_left = (int'(len) > 64) ? 64 : int'(len);
      if (m_left == 0) m_done = 1'b1;
      else             m_in_burst = 1'b1;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic random_read();
    en   = 1'($urandom_range(1));
    addr = 6'($urandom_range(63));
  endtask

  task automatic read_check(input string name, input int a, input logic [3:0] exp);
    en   = 1'b1;
    addr = 6'(a);
    #1;
    chk(name, 32'(dout), 32'(exp));
  endtask

  // Compare process: DUT outputs against the model on every falling edge.
  always @(negedge clk) begin
    if (checking) begin
      chk("busy", 32'(busy), 32'(m_in_burst | m_done));
      chk("din_ready", 32'(din_ready), 32'(m_in_burst));
      chk("done", 32'(done), 32'(m_done));
      if (!en) chk("dout_dis", 32'(dout), 32'h0);
      else if (m_known[addr]) chk("dout", 32'(dout), 32'(m_mem[addr]));
    end
  end

  // One burst. dmode: 0 = low nibble of write address, 1 = random, 2 = 0xA + index.
  // vmask != 0 gives an explicit din_valid pattern per WRITE cycle, else vpct %.
  // gap = cycles from last handshake (or from start) to the done pulse.
  task automatic burst(input string tag, input int b, input int l, input int vpct,
                       input int vmask, input int dmode, input bit poke,
                       output int hs, output int rdy, output int dones, output int gap);
    int last_c;
    int done_c;
    start     = 1'b1;
    base_addr = 6'(b);
    len       = 7'(l);
    din_valid = 1'b0;
    cycle();
    start  = 1'b0;
    hs     = 0;
    rdy    = 0;
    dones  = 0;
    last_c = -1;
    done_c = -1000;
    for (int c = 0; c < 600; c++) begin
      if (done === 1'b1) begin
        dones++;
        done_c    = c;
        din_valid = 1'b0;
        start     = 1'b0;
        random_read();
        cycle();
        break;
      end
      if (vmask != 0) din_valid = (((vmask >> c) & 1) != 0);
      else            din_valid = ($urandom_range(99) < vpct);
      case (dmode)
        0:       din = 4'((b + hs) % 16);
        2:       din = 4'(10 + hs);
        default: din = 4'($urandom_range(15));
      endcase
      start     = poke && (c == 2);
      base_addr = 6'(b + 10);
      if (din_ready === 1'b1) begin
        rdy++;
        if (din_valid) begin
          hs++;
          last_c = c;
        end
      end
      random_read();
      cycle();
    end
    start = 1'b0;
    gap   = done_c - last_c;
    $display("burst %s base=%0d len=%0d handshakes=%0d ready_cycles=%0d dones=%0d",
             tag, b, l, hs, rdy, dones);
  endtask

  initial begin
    int hs, rdy, dones, gap;
    for (int i = 0; i < 64; i++) m_known[i] = 1'b0;
    rst = 1'b1; start = 1'b0; base_addr = '0; len = '0;
    din = '0; din_valid = 1'b0; en = 1'b0; addr = '0;
    cycle();
    checking = 1'b1;
    cycle();
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_ready", 32'(din_ready), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    rst = 1'b0;
    cycle();

    // Full fill, data = address low nibble.
    burst("fill", 0, 64, 100, 0, 0, 1'b0, hs, rdy, dones, gap);
    chk("fill_ready_cycles", 32'(rdy), 32'd64);
    chk("fill_hs", 32'(hs), 32'd64);
    chk("fill_dones", 32'(dones), 32'd1);
    chk("fill_gap", 32'(gap), 32'd1);
    read_check("fill_rd63", 63, 4'hF);
    read_check("fill_rd1", 1, 4'h1);
    read_check("fill_rd22", 22, 4'h6);
    read_check("fill_rd33", 33, 4'h1);
    en = 1'b0; #1;
    chk("fill_en0", 32'(dout), 32'h0);
    cycle();

    // Wrap-around 62,63,0,1.
    burst("wrap", 62, 4, 100, 0, 2, 1'b0, hs, rdy, dones, gap);
    chk("wrap_dones", 32'(dones), 32'd1);
    read_check("wrap_rd62", 62, 4'hA);
    read_check("wrap_rd63", 63, 4'hB);
    read_check("wrap_rd0", 0, 4'hC);
    read_check("wrap_rd1", 1, 4'hD);
    read_check("wrap_rd2", 2, 4'h2);

    // Stall pattern 1,0,0,1,0,1.
    burst("stall", 10, 3, 0, 32'h29, 2, 1'b0, hs, rdy, dones, gap);
    chk("stall_hs", 32'(hs), 32'd3);
    chk("stall_gap", 32'(gap), 32'd1);
    chk("stall_dones", 32'(dones), 32'd1);
    read_check("stall_rd10", 10, 4'hA);
    read_check("stall_rd12", 12, 4'hC);
    read_check("stall_rd13", 13, 4'hD);

    // Zero length: done the cycle after start, no write.
    burst("len0", 5, 0, 100, 0, 2, 1'b0, hs, rdy, dones, gap);
    chk("len0_hs", 32'(hs), 32'd0);
    chk("len0_gap", 32'(gap), 32'd1);
    chk("len0_dones", 32'(dones), 32'd1);
    read_check("len0_rd5", 5, 4'h5);

    // Reset after 3 handshakes of an 8-word burst.
    start = 1'b1; base_addr = 6'd30; len = 7'd8; din_valid = 1'b0;
    cycle();
    start = 1'b0; din_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din = 4'(10 + i);
      cycle();
    end
    rst = 1'b1; din = 4'hE;
    cycle();
    rst = 1'b0; din_valid = 1'b0;
    chk("rstmid_busy", 32'(busy), 32'h0);
    chk("rstmid_ready", 32'(din_ready), 32'h0);
    chk("rstmid_done", 32'(done), 32'h0);
    for (int i = 0; i < 3; i++) cycle();
    read_check("rstmid_rd30", 30, 4'hA);
    read_check("rstmid_rd32", 32, 4'hC);
    read_check("rstmid_rd33", 33, 4'h1);
    $display("reset_mid base=30 len=8 handshakes=3 reset applied");

    // start re-asserted during WRITE must be ignored.
    burst("ignored_start", 40, 5, 100, 0, 2, 1'b1, hs, rdy, dones, gap);
    chk("ign_hs", 32'(hs), 32'd5);
    chk("ign_dones", 32'(dones), 32'd1);
    cycle();
    chk("ign_idle_busy", 32'(busy), 32'h0);
    read_check("ign_rd40", 40, 4'hA);
    read_check("ign_rd44", 44, 4'hE);
    read_check("ign_rd50", 50, 4'h2);

    // Oversized length saturates to 64 words.
    burst("len100", 20, 100, 70, 0, 1, 1'b0, hs, rdy, dones, gap);
    chk("len100_hs", 32'(hs), 32'd64);
    chk("len100_dones", 32'(dones), 32'd1);

    // Random bursts with random idle gaps and reads.
    for (int n = 0; n < 20; n++) begin
      int l;
      l = $urandom_range(100);
      burst("random", $urandom_range(63), l, $urandom_range(100, 40), 0, 1,
            1'($urandom_range(1)), hs, rdy, dones, gap);
      chk("rand_hs", 32'(hs), 32'((l > 64) ? 64 : l));
      chk("rand_dones", 32'(dones), 32'd1);
      for (int k = $urandom_range(3); k > 0; k--) begin
        random_read();
        cycle();
      end
    end

    cycle();
    checking = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_burst_wr.md
# ram_burst_wr

Write-side companion to the team's 64x4 asynchronous ROM. A 64-word x 4-bit RAM that fills itself from a valid/ready data stream in address-sequential bursts. It keeps the same combinational read port as the ROM (`en`, `addr`, `dout`). Downstream logic can therefore read a table that was loaded at run time instead of one fixed at elaboration.

## Interface
- `ADDR_W`, 6, address width
- `DATA_W`, 4, data width
- `DEPTH`, 64, number of words; equals 2**ADDR_W

- `clk`  in  1  single clock; all state changes on its rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  burst request; sampled only in IDLE
- `base_addr`  in  ADDR_W  first write address; latched with `start`
- `len`  in  ADDR_W+1  burst length in words; latched with `start`
- `din`  in  DATA_W  write data
- `din_valid`  in  1  `din` is valid
- `din_ready`  out  1  block accepts `din` this cycle
- `busy`  out  1  burst in progress (state != IDLE)
- `done`  out  1  one-cycle pulse at burst completion
- `en`  in  1  read enable
- `addr`  in  ADDR_W  read address
- `dout`  out  DATA_W  read data, combinational

## Operation
- Storage is `DEPTH` x `DATA_W` registers.
  - Reset does not clear contents; they hold their value across `rst`.
  - A location never written reads X in simulation.
- FSM has three states: IDLE, WRITE, DONE.
- **IDLE**
  - Outputs: `busy`=0, `din_ready`=0, `done`=0.
  - On `start`=1: latch `ptr`<=`base_addr` and `remaining`<=min(`len`, DEPTH).
    - `len`>DEPTH saturates to DEPTH.
  - If the latched length is 0, go to DONE; no write occurs.
  - Otherwise go to WRITE.
- **WRITE**
  - Outputs: `busy`=1, `din_ready`=1.
  - A handshake is `din_valid`&`din_ready` at a rising edge. On each handshake:
    - `mem[ptr]`<=`din`
    - `ptr`<=`ptr`+1, modulo DEPTH (wraps 63->0)
    - `remaining`<=`remaining`-1
  - The handshake that brings `remaining` to 0 moves the FSM to DONE.
  - With `din_valid`=0, the FSM holds state and no write occurs; stalls of any length are allowed.
- **DONE**
  - Outputs: `busy`=1, `done`=1, `din_ready`=0.
  - Unconditionally returns to IDLE on the next edge.
- `start` asserted outside IDLE is ignored; it is not queued.
- `base_addr` and `len` are don't-care except on the `start` cycle in IDLE.
- Read port
  - `dout` = `en` ? `mem[addr]` : 0. Purely combinational and independent of FSM state.
  - Reads are allowed during a burst.
- Width rules
  - `ptr` is ADDR_W bits with natural wrap.
  - `remaining` is ADDR_W+1 bits and never underflows.

## Timing
- Reset values (edge with `rst`=1): state=IDLE, `busy`=0, `done`=0, `din_ready`=0, `ptr`=0, `remaining`=0.
  - `dout` still follows `en`/`addr`/memory.
- `rst` has priority over every other input.
- Reset mid-burst:
  - Aborts to IDLE on that edge with no `done` pulse.
  - Words written before the reset edge remain; a handshake coinciding with the reset edge is not written.
- `start` at edge N:
  - `busy`=1 and `din_ready`=1 from N to N+1.
  - The earliest write is at edge N+1.
- Zero-wait burst of L words:
  - Writes at edges N+1 .. N+L.
  - `done`=1 between edges N+L and N+L+1.
  - `busy` falls after edge N+L+1.
  - The earliest next `start` is sampled at edge N+L+1.
- `len`=0 at edge N: `done`=1 between N and N+1; back in IDLE after N+1.
- Write/read collision: when `addr` equals the address written at an edge, `dout` shows the old value before the edge and the new value after it, in the same cycle. There is no bypass.
- Throughput is one word per clock.

## Test plan
- Reset, then fill: `rst` 2 cycles, then `start`, `base_addr`=0, `len`=64, `din`=addr[3:0] each cycle with `din_valid`=1.
  - `din_ready` high for exactly 64 cycles, then `done` for 1 cycle.
  - With `en`=1, reads of addr 63, 1, 22, 33 return 4'hF, 4'h1, 4'h6, 4'h1.
  - With `en`=0, `dout`=4'h0.
- Wrap-around: `base_addr`=62, `len`=4, data A, B, C, D.
  - mem[62]=A, mem[63]=B, mem[0]=C, mem[1]=D.
  - mem[2] unchanged.
- Stall: `len`=3 with `din_valid` pattern 1,0,0,1,0,1.
  - Exactly 3 writes, to consecutive addresses.
  - `done` one cycle after the third handshake.
- Length edge cases:
  - `len`=0 gives `done` the cycle after `start`, with no memory change.
  - `len`=100 writes exactly 64 words, then `done`.
- Reset mid-burst: `len`=8 and `rst` asserted after 3 handshakes.
  - 3 words stored, 4th location unchanged.
  - No `done` pulse; `busy`=0 and `din_ready`=0 after the reset edge.
- Ignored `start`: re-assert `start` with new `base_addr` during WRITE.
  - Burst continues at the original addresses.
  - A single `done` pulse.
